// File: rtl/router_local_port.sv
// Router-side end of the NIC link: polarity generator, two-VC ingress/egress
// buffers, and a valid/ready bridge to the router switch.
module router_local_port #(
    parameter int DATA_W = 64,
    parameter int VC_BIT = 63,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              polarity,
    input  logic              nic_so,
    input  logic [DATA_W-1:0] nic_do,
    output logic              nic_ro,
    output logic              nic_si,
    output logic [DATA_W-1:0] nic_di,
    input  logic              nic_ri,
    output logic              sw_out_valid,
    output logic [DATA_W-1:0] sw_out_data,
    input  logic              sw_out_ready,
    input  logic              sw_in_valid,
    input  logic [DATA_W-1:0] sw_in_data,
    output logic              sw_in_ready,
    output logic [CNT_W-1:0]  rx_count,
    output logic [CNT_W-1:0]  tx_count,
    output logic              err_overflow
);

    logic                   r_pol;
    logic [1:0]             r_ing_full;
    logic [1:0]             r_egr_full;
    logic [1:0][DATA_W-1:0] r_ing_buf;
    logic [1:0][DATA_W-1:0] r_egr_buf;
    logic                   r_nic_si;
    logic [DATA_W-1:0]      r_nic_di;
    logic [CNT_W-1:0]       r_rx_cnt;
    logic [CNT_W-1:0]       r_tx_cnt;
    logic                   r_ovf;

    logic w_npol;
    logic w_vc_in;
    logic w_pop;
    logic w_push;
    logic w_send;

    // Link side owns VC[polarity], switch side owns VC[~polarity].
    assign w_npol  = ~r_pol;
    assign w_vc_in = nic_do[VC_BIT];

    assign polarity     = r_pol;
    assign nic_ro       = ~r_ing_full[r_pol];
    assign nic_si       = r_nic_si;
    assign nic_di       = r_nic_di;
    assign rx_count     = r_rx_cnt;
    assign tx_count     = r_tx_cnt;
    assign err_overflow = r_ovf;

    assign sw_out_valid = r_ing_full[w_npol];
    assign sw_out_data  = r_ing_buf[w_npol];
    assign sw_in_ready  = ~reset & ~r_egr_full[w_npol] & (sw_in_data[VC_BIT] == w_npol);

    assign w_pop  = sw_out_valid & sw_out_ready;
    assign w_push = sw_in_valid & sw_in_ready;
    // Blocking on r_nic_si covers the cycle before the NIC's registered ready falls.
    assign w_send = r_egr_full[r_pol] & nic_ri & ~r_nic_si;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pol      <= 1'b0;
            r_ing_full <= '0;
            r_egr_full <= '0;
            r_ing_buf  <= '0;
            r_egr_buf  <= '0;
            r_nic_si   <= 1'b0;
            r_nic_di   <= '0;
            r_rx_cnt   <= '0;
            r_tx_cnt   <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_pol <= ~r_pol;

            // A pop only clears a full flag, a capture only sets an empty one.
            if (w_pop)
                r_ing_full[w_npol] <= 1'b0;

            if (nic_so) begin
                if (!r_ing_full[w_vc_in]) begin
                    r_ing_buf[w_vc_in]  <= nic_do;
                    r_ing_full[w_vc_in] <= 1'b1;
                    r_rx_cnt            <= r_rx_cnt + CNT_W'(1);
                end else begin
                    r_ovf <= 1'b1;
                end
            end

            if (w_push) begin
                r_egr_buf[w_npol]  <= sw_in_data;
                r_egr_full[w_npol] <= 1'b1;
            end

            if (w_send) begin
                r_nic_si          <= 1'b1;
                r_nic_di          <= r_egr_buf[r_pol];
                r_egr_full[r_pol] <= 1'b0;
                r_tx_cnt          <= r_tx_cnt + CNT_W'(1);
            end else begin
                r_nic_si <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_router_local_port.sv
// Directed bench for router_local_port: reset state, ingress, egress,
// send pacing, overflow and mid-operation reset.
module tb_router_local_port;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              polarity;
    logic              nic_so;
    logic [DATA_W-1:0] nic_do;
    logic              nic_ro;
    logic              nic_si;
    logic [DATA_W-1:0] nic_di;
    logic              nic_ri;
    logic              sw_out_valid;
    logic [DATA_W-1:0] sw_out_data;
    logic              sw_out_ready;
    logic              sw_in_valid;
    logic [DATA_W-1:0] sw_in_data;
    logic              sw_in_ready;
    logic [CNT_W-1:0]  rx_count;
    logic [CNT_W-1:0]  tx_count;
    logic              err_overflow;

    int   n_chk  = 0;
    int   n_fail = 0;
    logic exp_pol;

    localparam logic [63:0] VC1 = 64'h8000_0000_0000_0000;

    router_local_port dut (
        .clk(clk), .reset(reset), .polarity(polarity),
        .nic_so(nic_so), .nic_do(nic_do), .nic_ro(nic_ro),
        .nic_si(nic_si), .nic_di(nic_di), .nic_ri(nic_ri),
        .sw_out_valid(sw_out_valid), .sw_out_data(sw_out_data), .sw_out_ready(sw_out_ready),
        .sw_in_valid(sw_in_valid), .sw_in_data(sw_in_data), .sw_in_ready(sw_in_ready),
        .rx_count(rx_count), .tx_count(tx_count), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and check the polarity sequence.
    task automatic step();
        exp_pol = reset ? 1'b0 : ~exp_pol;
        @(posedge clk);
        #1;
        chk("polarity", {63'd0, polarity}, {63'd0, exp_pol});
    endtask

    initial begin
        logic prev_si;
        int   n_send;
        logic [63:0] di_sum;

        reset = 1'b1; nic_so = 1'b0; nic_do = '0; nic_ri = 1'b1;
        sw_out_ready = 1'b0; sw_in_valid = 1'b0; sw_in_data = VC1;
        exp_pol = 1'b0;

        // Reset state (sw_in_data would match VC1 here, ready still forced low)
        step(); step();
        chk("rst_nic_ro", 64'(nic_ro), 64'd1);
        chk("rst_nic_si", 64'(nic_si), 64'd0);
        chk("rst_nic_di", nic_di, 64'd0);
        chk("rst_sw_out_valid", 64'(sw_out_valid), 64'd0);
        chk("rst_sw_in_ready", 64'(sw_in_ready), 64'd0);
        chk("rst_rx", 64'(rx_count), 64'd0);
        chk("rst_tx", 64'(tx_count), 64'd0);
        chk("rst_err", 64'(err_overflow), 64'd0);
        reset = 1'b0; sw_in_data = '0;

        // Idle: pol 0,1,0,1
        step(); chk("idle_ro", 64'(nic_ro), 64'd1);
        step(); chk("idle_si", 64'(nic_si), 64'd0);
        step(); chk("idle_valid", 64'(sw_out_valid), 64'd0);

        // Ingress VC0 packet in a pol=1 cycle
        nic_so = 1'b1; nic_do = 64'h0000_0000_0000_00A5;
        step(); nic_so = 1'b0; nic_do = '0;
        chk("ing_rx", 64'(rx_count), 64'd1);
        chk("ing_valid_pol0", 64'(sw_out_valid), 64'd0);
        step();
        chk("ing_valid_pol1", 64'(sw_out_valid), 64'd1);
        chk("ing_data", sw_out_data, 64'h00A5);
        sw_out_ready = 1'b1;
        step(); sw_out_ready = 1'b0;
        chk("ing_ro_after_pop", 64'(nic_ro), 64'd1);
        chk("ing_valid_after_pop0", 64'(sw_out_valid), 64'd0);
        step();
        chk("ing_valid_after_pop1", 64'(sw_out_valid), 64'd0);

        // Egress VC1 packet offered in pol=0
        step();
        sw_in_valid = 1'b1; sw_in_data = VC1 | 64'h77; #1;
        chk("egr_ready_pol0", 64'(sw_in_ready), 64'd1);
        step();
        chk("egr_ready_pol1", 64'(sw_in_ready), 64'd0);
        sw_in_valid = 1'b0;
        step();
        chk("egr_si", 64'(nic_si), 64'd1);
        chk("egr_di", nic_di, VC1 | 64'h77);
        chk("egr_tx", 64'(tx_count), 64'd1);
        step();
        chk("egr_si_one_cycle", 64'(nic_si), 64'd0);

        // Load both egress buffers with the NIC not ready
        nic_ri = 1'b0;
        step();
        sw_in_valid = 1'b1; sw_in_data = VC1 | 64'h1; #1;
        chk("load_vc1_ready", 64'(sw_in_ready), 64'd1);
        step();
        sw_in_data = 64'h2; #1;
        chk("load_vc0_ready", 64'(sw_in_ready), 64'd1);
        step(); sw_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sw_in_data = exp_pol ? 64'h0 : VC1; #1;
            chk("hold_full_ready", 64'(sw_in_ready), 64'd0);
            chk("hold_si", 64'(nic_si), 64'd0);
            step();
        end
        nic_ri = 1'b1;
        prev_si = 1'b0; n_send = 0; di_sum = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("si_not_back_to_back", 64'(prev_si & nic_si), 64'd0);
            if (nic_si) begin
                n_send++;
                di_sum += nic_di;
            end
            prev_si = nic_si;
        end
        chk("drain_sends", 64'(n_send), 64'd2);
        chk("drain_di_sum", di_sum, VC1 | 64'h3);
        chk("drain_tx", 64'(tx_count), 64'd3);

        // Overflow on VC1 (pol=0 cycle here)
        nic_so = 1'b1; nic_do = VC1 | 64'hB1;
        step(); nic_so = 1'b0;
        chk("ovf_rx_first", 64'(rx_count), 64'd2);
        chk("ovf_ro_full", 64'(nic_ro), 64'd0);
        step();
        chk("ovf_valid", 64'(sw_out_valid), 64'd1);
        chk("ovf_data_first", sw_out_data, VC1 | 64'hB1);
        nic_so = 1'b1; nic_do = VC1 | 64'hB2;
        step(); nic_so = 1'b0;
        chk("ovf_err", 64'(err_overflow), 64'd1);
        chk("ovf_rx_same", 64'(rx_count), 64'd2);
        step();
        chk("ovf_data_kept", sw_out_data, VC1 | 64'hB1);
        chk("ovf_err_sticky", 64'(err_overflow), 64'd1);

        // Mid-operation reset with ing_buf[0], egr_buf[1] full and nic_si high
        nic_ri = 1'b0;
        nic_so = 1'b1; nic_do = 64'hC0;
        sw_in_valid = 1'b1; sw_in_data = VC1 | 64'hE1;
        step();
        nic_so = 1'b0; sw_in_data = 64'hE0;
        step();
        sw_in_valid = 1'b0; nic_ri = 1'b1;
        step();
        chk("pre_rst_si", 64'(nic_si), 64'd1);
        chk("pre_rst_di", nic_di, 64'hE0);
        reset = 1'b1; sw_in_data = VC1;
        step();
        chk("mid_rst_si", 64'(nic_si), 64'd0);
        chk("mid_rst_di", nic_di, 64'd0);
        chk("mid_rst_rx", 64'(rx_count), 64'd0);
        chk("mid_rst_tx", 64'(tx_count), 64'd0);
        chk("mid_rst_err", 64'(err_overflow), 64'd0);
        chk("mid_rst_valid", 64'(sw_out_valid), 64'd0);
        chk("mid_rst_ro", 64'(nic_ro), 64'd1);
        chk("mid_rst_in_ready", 64'(sw_in_ready), 64'd0);
        reset = 1'b0;
        step();
        sw_in_data = 64'h0; #1;
        chk("post_rst_valid", 64'(sw_out_valid), 64'd0);
        chk("post_rst_ro", 64'(nic_ro), 64'd1);
        chk("post_rst_egr0_empty", 64'(sw_in_ready), 64'd1);
        step();
        chk("post_rst_si", 64'(nic_si), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
